// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX byte port between NUM_REQ producers.
// An owner holds the port for a whole text line; release is on newline or on idle timeout.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int LOCK_TIMEOUT = 1024
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [8*NUM_REQ-1:0]       req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       tx_valid,
   output logic [7:0]                 tx_data,
   input  logic                       tx_ready,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy,
   output logic                       end_flag
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam int CW  = $clog2(LOCK_TIMEOUT);
   localparam logic [CW-1:0]  CNT_MAX  = CW'(LOCK_TIMEOUT - 1);
   localparam logic [IDW-1:0] LAST_RST = IDW'(NUM_REQ - 1);
   localparam logic [7:0]     BYTE_NL  = 8'h0a;
   localparam logic [7:0]     BYTE_END = 8'h7e;

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_LOCKED = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   owner_q, owner_d;
   logic [IDW-1:0]   last_q, last_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             end_q, end_d;
   logic [7:0]       req_byte_s [NUM_REQ];
   logic             xfer_s;

   // First valid requester after 'last', wrapping; descending loop lets the nearest one win.
   function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [IDW-1:0]     last);
      logic [IDW-1:0] pick;
      logic [IDW-1:0] idx;
      pick = last;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx  = IDW'((int'(last) + k) % NUM_REQ);
         pick = valid[idx] ? idx : pick;
      end
      return pick;
   endfunction

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign req_byte_s[g] = req_data[8*g+7 : 8*g];
   end

   // Pass-through of the owner's stream while locked; nothing is offered in IDLE.
   always_comb begin
      tx_valid  = 1'b0;
      tx_data   = 8'h00;
      req_ready = {NUM_REQ{1'b0}};
      if (state_q == S_LOCKED) begin
         tx_valid           = req_valid[owner_q];
         tx_data            = req_byte_s[owner_q];
         req_ready[owner_q] = tx_ready;
      end else begin
         tx_valid = 1'b0;
      end
   end

   assign xfer_s = tx_valid & tx_ready;

   // Next-state, ownership, idle-counter and end-of-test flag computation.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      if (xfer_s && (tx_data == BYTE_END)) begin
         end_d = 1'b1;
      end else begin
         end_d = end_q;
      end
      case (state_q)
         S_IDLE: begin
            cnt_d = {CW{1'b0}};
            if (|req_valid) begin
               state_d = S_LOCKED;
               owner_d = rr_pick(req_valid, last_q);
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOCKED: begin
            // Newline and timeout in the same cycle collapse into one identical release.
            if ((xfer_s && (tx_data == BYTE_NL)) || (!xfer_s && (cnt_q == CNT_MAX))) begin
               state_d = S_IDLE;
               last_d  = owner_q;
               cnt_d   = {CW{1'b0}};
            end else if (xfer_s) begin
               cnt_d = {CW{1'b0}};
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = {CW{1'b0}};
         end
      endcase
      busy_d = (state_d == S_LOCKED);
   end

   // State and flag registers; reset aborts any line in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         owner_q <= {IDW{1'b0}};
         last_q  <= LAST_RST;
         cnt_q   <= {CW{1'b0}};
         busy_q  <= 1'b0;
         end_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         end_q   <= end_d;
      end
   end

   assign grant_id = owner_q;
   assign busy     = busy_q;
   assign end_flag = end_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART0 transmit byte port, the data register at 0x4000_0000, between up to NUM_REQ byte producers. Example producers: the CPU print path, the debug/trace engine and the self-test sequencer. Arbitration is round-robin, and an owner keeps the port for a whole text line: lock is released on 0x0a or on idle timeout. Lines from different sources therefore never interleave in the UART stream or in the simulation log. The block also raises a sticky end-of-test flag when the 0x7e terminator byte is transmitted.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- LOCK_TIMEOUT, 1024, idle cycles in LOCKED before forced release (>=2)
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NUM_REQ  per-requester byte valid
- req_data  input  8*NUM_REQ  per-requester byte; requester i on bits [8i+7:8i]
- req_ready  output  NUM_REQ  per-requester byte accepted this cycle
- tx_valid  output  1  byte valid toward UART TX core
- tx_data  output  8  byte toward UART TX core
- tx_ready  input  1  UART TX core can accept a byte
- grant_id  output  clog2(NUM_REQ)  current or last owner index
- busy  output  1  high while in LOCKED
- end_flag  output  1  sticky; set when 0x7e is transferred

## Operation
- States: IDLE, LOCKED.
- IDLE:
  - tx_valid=0, req_ready=0.
  - If any req_valid, select the first set bit searching from (last_owner+1) mod NUM_REQ upward with wrap.
  - Register the selected index as owner and grant_id, then go to LOCKED.
- LOCKED, combinational pass-through:
  - tx_valid = req_valid[owner]
  - tx_data = req_data[owner]
  - req_ready[owner] = tx_ready
  - all other req_ready bits = 0
- Transfer: tx_valid & tx_ready in LOCKED.
- Transfer of 0x0a:
  - last_owner <= owner, next state IDLE.
  - The newline byte itself is forwarded.
- Transfer of 0x7e: end_flag <= 1. It stays set until reset and is not a release condition.
- Idle counter, width clog2(LOCK_TIMEOUT):
  - Cleared on entry to LOCKED and on every transfer.
  - Otherwise increments each LOCKED cycle.
  - At LOCK_TIMEOUT-1 without a transfer: last_owner <= owner, go to IDLE.
- A requester that deasserts req_valid mid-line keeps the lock until newline or timeout. Its byte order is preserved.
- Requesters not granted see req_ready=0 and must hold valid/data stable (AXI-stream-style rule, checked by assertion in bench).
- Reset values:
  - state IDLE
  - owner 0, grant_id 0
  - last_owner NUM_REQ-1, so the first grant search starts at requester 0
  - counter 0
  - busy 0, end_flag 0, tx_valid 0, req_ready 0

## Timing
- Grant latency: req_valid rises in IDLE at cycle N; state becomes LOCKED at edge N+1; tx_valid is high in cycle N+1.
- Throughput while locked: one byte per cycle when tx_ready is held high.
- Release costs one IDLE cycle: newline transferred at cycle M, IDLE in M+1, earliest next grant visible in M+2. The same requester may win again only if no other requester is valid.
- A newline transfer and a timeout expiry in the same cycle count as one release, with identical result.
- busy = (state==LOCKED), registered.
- end_flag is set at the edge following the 0x7e transfer.
- grant_id changes only on IDLE->LOCKED.
- Reset asserted mid-line aborts the line: outputs return to reset values asynchronously, and the partial line is not resumed.
- No combinational path from tx_ready to tx_valid. A combinational path from tx_ready to req_ready is permitted.

## Test plan
- Single requester: req0 sends "OK\n" with tx_ready=1 -> tx_data sequence 0x4F,0x4B,0x0A on consecutive cycles starting one cycle after req_valid; busy falls the cycle after 0x0A.
- Contention: req0, req1 and req2 all valid from reset, each with a 3-byte line -> lines appear in order req0, req1, req2 with no interleaving; grant_id 0,1,2; one IDLE cycle between lines.
- Fairness wrap: req3 finishes, then req0 and req3 both valid -> req0 granted (search from 0 after wrap).
- Timeout: req1 sends 0x41, then drops valid for LOCK_TIMEOUT cycles while req2 is valid -> forced release after exactly LOCK_TIMEOUT idle cycles; req2 granted; 0x41 not repeated.
- Backpressure plus terminator: tx_ready toggles 1/0 while req0 sends 0x7E,0x0A -> each byte is held stable while tx_ready=0; end_flag rises after the 0x7E transfer and stays high.
- Reset mid-line: assert rst_n low after 2 of 5 bytes -> tx_valid, busy and end_flag go to 0 immediately; after release, the first grant goes to requester 0.
